ospfb_frame_sequencer: RTL
==========================

// Module: ospfb_frame_sequencer
// PURPOSE
//  Run-control sequencer wrapped around the OSPFB datapath.
//  Gates ADC samples into the PFB, discards output frames until the PTAPS-deep filter is primed,
//  frames the FFT_LEN-beat output stream with tlast and tracks the oversampling phase rotation index.
//  Flags input overflow.
//  Sits between the ADC AXIS source and the OSPFB s/m AXIS ports in the top level.
// PARAMETERS
//  WIDTH       16   sample width on all AXIS data ports (two's complement, passed through untouched)
//  FFT_LEN     512  output frame length M (beats per frame)
//  DEC_FAC     384  decimation D (new input samples per frame); 0 < DEC_FAC <= FFT_LEN
//  PTAPS       8    polyphase taps; first PTAPS-1 output frames are discarded
//  FCNT_W      32   width of delivered-frame counter
// PORTS
//  clk           in   1             system clock
//  rst           in   1             asynchronous reset, ACTIVE-LOW
//  en            in   1             run request (level)
//  s_tdata       in   WIDTH         ADC sample
//  s_tvalid      in   1             ADC sample valid
//  s_tready      out  1             ADC sample accepted
//  pfb_s_tdata   out  WIDTH         sample to OSPFB (= s_tdata)
//  pfb_s_tvalid  out  1             sample valid to OSPFB
//  pfb_s_tready  in   1             OSPFB input ready
//  pfb_m_tdata   in   WIDTH         OSPFB output beat
//  pfb_m_tvalid  in   1             OSPFB output valid
//  pfb_m_tready  out  1             OSPFB output ready
//  m_tdata       out  WIDTH         framed output (= pfb_m_tdata)
//  m_tvalid      out  1             framed output valid
//  m_tready      in   1             downstream ready
//  m_tlast       out  1             last beat of FFT_LEN frame
//  phase_idx     out  clog2(FFT_LEN) rotation index n*D mod M of current output frame
//  frame_cnt     out  FCNT_W        delivered (non-discarded) frames since run start, wraps
//  busy          out  1             state != IDLE
//  overflow      out  1             sticky: ADC beat offered while gated in RUN
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all counters 0; every output 0 except passthrough tdata.
//  Handshake:
//   - in_gate=1 in PRIME/RUN, and in STOP until the in-sample counter wraps.
//   - pfb_s_tvalid = s_tvalid & in_gate; s_tready = pfb_s_tready & in_gate.
//   - Discard (dframes < PTAPS-1): pfb_m_tready=1, m_tvalid=0.
//   - Otherwise: m_tvalid = pfb_m_tvalid; pfb_m_tready = m_tready. Combinational, zero latency.
//  Counters (advance only on a handshake):
//   - icnt mod DEC_FAC on s beats.
//   - ocnt mod FFT_LEN on pfb_m beats.
//   - m_tlast = (ocnt==FFT_LEN-1) & m_tvalid.
//  On each output frame end (ocnt wrap):
//   - phase_idx <= (phase_idx+DEC_FAC) mod FFT_LEN, via subtract-if->=FFT_LEN, no divider.
//   - frame_cnt++ if delivered, else dframes++ (saturating at PTAPS-1).
//  FSM:
//   - IDLE -> PRIME on en=1. Clear icnt/ocnt/phase_idx/frame_cnt/dframes/overflow.
//   - PRIME -> RUN when dframes reaches PTAPS-1. Skip directly to RUN if PTAPS=1.
//   - RUN/PRIME -> STOP on en=0.
//   - STOP: input accepted only to complete the current DEC_FAC block. Output continues.
//     -> IDLE at the first output frame end after input is closed.
//   - en=1 while in STOP is ignored until IDLE is reached, then a new run starts next cycle.
//  Boundaries:
//   - overflow sets when state==RUN & s_tvalid & ~s_tready. It is not set in PRIME or STOP.
//   - Simultaneous last input beat and output frame end in STOP: both are counted and the FSM goes to IDLE.
//   - Stall: m_tready=0 holds tlast/phase_idx/counters stable.
//   - rst low mid-frame: immediate return to IDLE, no partial-frame completion.
//  phase_idx and frame_cnt change only on a beat after the tlast handshake.
// TESTING  (FFT_LEN=8, DEC_FAC=6, PTAPS=2 unless noted)
//  1. Reset, en=1, continuous valid in/out, m_tready=1.
//     -> first 8 pfb_m beats dropped (m_tvalid=0).
//     -> delivered frames have phase_idx 6,4,2,0,6 (frame 0 is discarded at phase 0).
//     -> m_tlast on every 8th beat; frame_cnt=1,2,...
//  2. Random m_tready backpressure (50%).
//     -> no lost or duplicated beats; tlast spacing exactly 8 accepted beats; phase sequence unchanged.
//  3. en dropped after 3 input samples of a block.
//     -> exactly 3 more samples accepted, s_tready=0 after.
//     -> output finishes current frame with tlast, then busy=0.
//  4. In RUN, pfb_s_tready=0 while s_tvalid=1 for 1 cycle -> overflow=1 and stays set.
//     -> next en rise from IDLE clears it.
//  5. rst asserted low mid-frame (ocnt=4).
//     -> all outputs 0 immediately; restart gives phase_idx=0 and re-primes (8 beats dropped).
//  6. PTAPS=1, DEC_FAC=FFT_LEN=8.
//     -> no discard; phase_idx constant 0; first pfb_m beat delivered.

Source files
------------

// File: rtl/ospfb_frame_sequencer_if.sv
// Stream bundle between the ADC source, the OSPFB datapath and the downstream sink.
// A beat transfers on a rising clk edge where tvalid & tready; tdata/tlast are meaningful only while tvalid.
interface ospfb_frame_sequencer_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] s_tdata;
   logic             s_tvalid;
   logic             s_tready;
   logic [WIDTH-1:0] pfb_s_tdata;
   logic             pfb_s_tvalid;
   logic             pfb_s_tready;
   logic [WIDTH-1:0] pfb_m_tdata;
   logic             pfb_m_tvalid;
   logic             pfb_m_tready;
   logic [WIDTH-1:0] m_tdata;
   logic             m_tvalid;
   logic             m_tready;
   logic             m_tlast;

   // Environment side: ADC source, OSPFB datapath and downstream sink.
   modport master (
      output s_tdata, s_tvalid, pfb_s_tready, pfb_m_tdata, pfb_m_tvalid, m_tready,
      input  s_tready, pfb_s_tdata, pfb_s_tvalid, pfb_m_tready, m_tdata, m_tvalid, m_tlast
   );

   // Sequencer side.
   modport slave (
      input  s_tdata, s_tvalid, pfb_s_tready, pfb_m_tdata, pfb_m_tvalid, m_tready,
      output s_tready, pfb_s_tdata, pfb_s_tvalid, pfb_m_tready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/ospfb_frame_sequencer.sv
// Run-control sequencer around the OSPFB: gates ADC input, drops priming frames,
// frames the output with tlast and tracks the oversampling phase rotation.
module ospfb_frame_sequencer #(
   parameter int WIDTH   = 16,
   parameter int FFT_LEN = 512,
   parameter int DEC_FAC = 384,
   parameter int PTAPS   = 8,
   parameter int FCNT_W  = 32,
   localparam int PW     = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   ospfb_frame_sequencer_if.slave bus,
   output logic [PW-1:0]     phase_idx,
   output logic [FCNT_W-1:0] frame_cnt,
   output logic              busy,
   output logic              overflow,
   output logic [1:0]        state
);
   localparam int IW  = (DEC_FAC > 1) ? $clog2(DEC_FAC) : 1;
   localparam int DFW = (PTAPS > 1) ? $clog2(PTAPS) : 1;
   localparam logic [IW-1:0]  ICNT_LAST = IW'(DEC_FAC - 1);
   localparam logic [PW-1:0]  OCNT_LAST = PW'(FFT_LEN - 1);
   localparam logic [DFW-1:0] DF_FULL   = DFW'(PTAPS - 1);
   localparam logic [PW:0]    DEC_EXT   = (PW + 1)'(DEC_FAC);
   localparam logic [PW:0]    LEN_EXT   = (PW + 1)'(FFT_LEN);

   typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2, STOP = 2'd3} state_t;

   state_t         st;
   logic [IW-1:0]  icnt;
   logic [PW-1:0]  ocnt;
   logic [DFW-1:0] dframes;
   logic           in_open;

   logic [WIDTH-1:0] s_data;
   logic in_gate, discard, out_act;
   logic s_beat, o_beat, frame_end, in_last;
   logic [IW-1:0] icnt_nxt;
   logic [PW-1:0] ocnt_nxt;
   logic [PW-1:0] phase_nxt;
   logic [PW:0]   phase_sum;

   assign s_data          = bus.s_tdata;
   assign bus.pfb_s_tdata = s_data;
   assign bus.m_tdata     = bus.pfb_m_tdata;

   assign in_gate = (st == PRIME) || (st == RUN) || ((st == STOP) && in_open);
   assign discard = (dframes != DF_FULL);
   assign out_act = (st != IDLE);

   assign bus.pfb_s_tvalid = bus.s_tvalid & in_gate;
   assign bus.s_tready     = bus.pfb_s_tready & in_gate;
   assign bus.m_tvalid     = out_act & ~discard & bus.pfb_m_tvalid;
   assign bus.pfb_m_tready = out_act & (discard | bus.m_tready);
   assign bus.m_tlast      = bus.m_tvalid & (ocnt == OCNT_LAST);

   assign s_beat    = bus.s_tvalid & bus.s_tready;
   assign o_beat    = bus.pfb_m_tvalid & bus.pfb_m_tready;
   assign frame_end = o_beat & (ocnt == OCNT_LAST);
   assign in_last   = s_beat & (icnt == ICNT_LAST);

   // Rotation index advances by D modulo M using a single conditional subtract.
   always_comb begin
      icnt_nxt  = (icnt == ICNT_LAST) ? '0 : icnt + IW'(1);
      ocnt_nxt  = (ocnt == OCNT_LAST) ? '0 : ocnt + PW'(1);
      phase_sum = {1'b0, phase_idx} + DEC_EXT;
      phase_nxt = phase_sum[PW-1:0];
      if (phase_sum >= LEN_EXT) begin
         phase_sum = phase_sum - LEN_EXT;
         phase_nxt = phase_sum[PW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st        <= IDLE;
         icnt      <= '0;
         ocnt      <= '0;
         dframes   <= '0;
         in_open   <= 1'b0;
         phase_idx <= '0;
         frame_cnt <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
      end else if (st == IDLE) begin
         if (en) begin
            st        <= (PTAPS == 1) ? RUN : PRIME;
            busy      <= 1'b1;
            icnt      <= '0;
            ocnt      <= '0;
            dframes   <= '0;
            in_open   <= 1'b0;
            phase_idx <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
         end
      end else begin
         if (s_beat) icnt <= icnt_nxt;
         if (o_beat) ocnt <= ocnt_nxt;
         if (frame_end) begin
            phase_idx <= phase_nxt;
            if (discard) dframes   <= dframes + DFW'(1);
            else         frame_cnt <= frame_cnt + FCNT_W'(1);
         end
         if ((st == RUN) && bus.s_tvalid && !bus.s_tready) overflow <= 1'b1;

         if ((st == PRIME) || (st == RUN)) begin
            if (!en) begin
               // Keep input open only if this cycle leaves a partial DEC_FAC block.
               st      <= STOP;
               in_open <= s_beat ? (icnt_nxt != '0) : (icnt != '0);
            end else if ((st == PRIME) && frame_end && discard &&
                         (dframes + DFW'(1) == DF_FULL)) begin
               st <= RUN;
            end
         end else begin
            if (in_last) in_open <= 1'b0;
            if (frame_end && (!in_open || in_last)) begin
               st      <= IDLE;
               busy    <= 1'b0;
               in_open <= 1'b0;
            end
         end
      end
   end

   assign state = st;
endmodule
